banked_memory: RTL and testbench
================================

Name: banked_memory

Overview:
- Parametrised single-port word memory of NUM_BANKS chip-selected banks, each WORDS_PER_BANK words of DATA_W bits.
- Successor to the fixed 8-bit-address/32-bit-data lab memory. Adds per-byte write enables, a valid/ready request handshake, a registered read response and a post-reset zero-fill sweep.
- Sits between the datapath load/store unit and storage.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- WORDS_PER_BANK, 64, words per bank; power of two, >= 2.
- NUM_BANKS, 4, number of chip-selected banks; power of two, >= 1.
- ADDR_W, $clog2(NUM_BANKS*WORDS_PER_BANK) (8 at defaults), derived word-address width; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  block accepts requests (equals init_done)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address: upper log2(NUM_BANKS) bits = bank, lower bits = word index
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit i covers byte lane i (bits 8i+7:8i)
- rsp_valid  out  1  read data valid, single-cycle pulse
- rsp_rdata  out  DATA_W  read data
- bank_sel  out  NUM_BANKS  registered one-hot chip select of the last accepted request
- init_done  out  1  zero-fill sweep complete

Behaviour:
- Reset: while rst_n = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, bank_sel = 0, init_done = 0, FSM = INIT, sweep index = 0. Array contents are not reset directly; the sweep clears them.
- FSM states:
  - INIT: each cycle writes 0 to word index idx in all banks simultaneously (all byte lanes), then idx++. When idx = WORDS_PER_BANK-1, go to READY.
  - READY: terminal state.
  - INIT lasts exactly WORDS_PER_BANK cycles after the first clk edge with rst_n high. init_done and req_ready go to 1 on the edge that ends the last sweep write.
- Acceptance: a request is accepted on an edge where req_valid && req_ready. Requests with req_ready = 0 are ignored: no array change, no response, no bank_sel change.
- Write: on acceptance, only lanes with req_be[i] = 1 are updated in the addressed bank/word; other lanes keep their value. req_be = 0 writes nothing. Writes never produce rsp_valid.
- Read: accepted at edge N → rsp_valid = 1 and rsp_rdata = word contents after edge N-1, both registered on edge N+1 (latency 1).
  - rsp_valid stays high for one cycle only.
  - rsp_rdata holds its value until the next read response.
- Back-to-back:
  - Write then read of the same address on consecutive edges returns the new data.
  - One request per cycle; sustained throughput is 1 request/cycle, no bubbles.
- bank_sel: updated on every accepted request to onehot(bank field). It holds otherwise.
- Address: the full ADDR_W range maps to storage; there are no out-of-range addresses. Bank field = req_addr[ADDR_W-1 -: log2(NUM_BANKS)]. For NUM_BANKS = 1 the bank field is empty and bank_sel = 1 on any accept.
- Reset mid-operation: async clear of all outputs, and any pending read response is dropped. On release the sweep restarts from idx 0 and completes in WORDS_PER_BANK cycles again.
- X on req_* while req_valid = 0 must have no effect.

Decomposition:
- Shared package banked_memory_pkg:
  - function for bank-field width (0 when NUM_BANKS = 1);
  - FSM state typedef {INIT, READY};
  - byte-lane count constant DATA_W/8.
- One sub-module, mem_bank: a single bank with sync write, per-byte enables and a registered read port, instantiated NUM_BANKS times by generate.
- The top-level holds:
  - the FSM and sweep counter;
  - bank decode;
  - a read mux using the registered bank index;
  - the response register.

Test Plan:
- Reset then release:
  - init_done/req_ready stay 0 for exactly 64 cycles, then go to 1.
  - Reads of 0x00, 0x3F, 0x40, 0xFF return 0x00000000.
- Write addr 0x01 data 12, be 4'hF; next cycle read 0x01 → rsp_valid one cycle later, rsp_rdata = 0x0000000C. bank_sel = 4'b0001.
- Write 0x02 data 20 be 4'hF, then write 0x02 data 0xAABBCCDD be 4'b0010, then read 0x02 → 0x0000CC14.
- Bank boundary:
  - Write 0x3F = 0x11111111 → bank_sel 4'b0001.
  - Write 0x40 = 0x22222222 → bank_sel 4'b0010.
  - Reads return each value independently.
- Request with req_valid = 1 during INIT (write 0x05 data 0xDEADBEEF) → ignored. After init_done, read 0x05 → 0x00000000.
- Reset mid-sweep and mid-read:
  - Drop rst_n at sweep idx 30 → init_done restarts and rises 64 cycles after release.
  - Drop rst_n the cycle after a read is accepted → rsp_valid never pulses.

Source files
------------

// File: rtl/banked_memory_pkg.sv
// banked_memory_pkg
//   Shared definitions for the banked word memory:
//   - BYTE_W        : width of one byte lane
//   - state_e       : sequencer states (INIT = zero-fill sweep, READY = serving)
//   - bank_field_w  : width of the bank field in a word address (0 for a single bank)
//   - lane_cnt      : number of byte lanes in a word of a given width
package banked_memory_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int bank_field_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int lane_cnt(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank
//   One storage bank: synchronous write with per-byte-lane enables and a
//   registered read port. Storage is not reset; the owner clears it.
//   Ports:
//     clk      in  clock, rising edge
//     we       in  write enable
//     re       in  read enable (captures mem[idx] into rdata_p0)
//     idx      in  word index shared by read and write
//     wdata    in  write data
//     be       in  byte-lane enables, bit i covers bits 8i+7:8i
//     rdata_p0 out registered read data
module mem_bank
  import banked_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int LANES = lane_cnt(DATA_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] rdata_p0
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    // stage p0: read word captured
    if (re) begin
      rdata_p0 <= mem[idx];
    end
  end

endmodule

// File: rtl/banked_memory.sv
// banked_memory
//   Single-port word memory built from NUM_BANKS chip-selected banks of
//   WORDS_PER_BANK words. After reset a sweep writes zero to every word
//   (one index per cycle, all banks at once) before requests are accepted.
//   Reads return data one cycle after the bank captures it (latency 1 from
//   the accepting edge).
//   Ports:
//     clk, rst_n   clock / asynchronous active-low reset
//     req_valid    request present
//     req_ready    requests accepted (equals init_done)
//     req_write    1 = write, 0 = read
//     req_addr     word address {bank, word index}
//     req_wdata    write data
//     req_be       byte-lane enables
//     rsp_valid    single-cycle read response strobe
//     rsp_rdata    read data, held until the next response
//     bank_sel     one-hot bank of the last accepted request
//     init_done    zero-fill sweep complete
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_BANK = 64,
  parameter int NUM_BANKS      = 4,
  parameter int ADDR_W         = $clog2(NUM_BANKS * WORDS_PER_BANK)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [NUM_BANKS-1:0]   bank_sel,
  output logic                   init_done
);

  localparam int LANES  = lane_cnt(DATA_W);
  localparam int IDX_W  = $clog2(WORDS_PER_BANK);
  localparam int BANK_W = bank_field_w(NUM_BANKS);
  // Keep a 1-bit bank index even for a single bank so vectors stay legal.
  localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;

  logic               acc, acc_wr, acc_rd;
  logic [BSEL_W-1:0]  req_bank;
  logic [IDX_W-1:0]   req_idx;
  logic [NUM_BANKS-1:0] bank_dec;

  logic [NUM_BANKS-1:0] bank_we, bank_re;
  logic [IDX_W-1:0]   bank_idx;
  logic [DATA_W-1:0]  bank_wdata;
  logic [LANES-1:0]   bank_be;
  logic [DATA_W-1:0]  bank_rdata_p0 [NUM_BANKS];

  logic               vld_p0;
  logic [BSEL_W-1:0]  rd_bank_p0;

  assign init_done = (state_q == READY);
  assign req_ready = init_done;
  assign acc       = req_valid && req_ready;
  assign acc_wr    = acc && req_write;
  assign acc_rd    = acc && !req_write;

  // Sequencer: zero-fill sweep, then serve requests forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      INIT: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(WORDS_PER_BANK - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  // Address split: bank field on top, word index below.
  if (BANK_W > 0) begin : g_bank_field
    assign req_bank = req_addr[ADDR_W-1 -: BANK_W];
  end else begin : g_single_bank
    assign req_bank = '0;
  end
  assign req_idx = req_addr[IDX_W-1:0];

  always_comb begin
    bank_dec = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_dec[b] = (req_bank == BSEL_W'(b));
    end
  end

  // The sweep owns the bank ports during INIT; requests cannot be accepted then.
  always_comb begin
    bank_we    = '0;
    bank_re    = '0;
    bank_idx   = req_idx;
    bank_wdata = req_wdata;
    bank_be    = req_be;
    if (state_q == INIT) begin
      bank_we    = '1;
      bank_idx   = sweep_idx_q;
      bank_wdata = '0;
      bank_be    = '1;
    end else begin
      if (acc_wr) bank_we = bank_dec;
      if (acc_rd) bank_re = bank_dec;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (WORDS_PER_BANK)
    ) u_bank (
      .clk      (clk),
      .we       (bank_we[g]),
      .re       (bank_re[g]),
      .idx      (bank_idx),
      .wdata    (bank_wdata),
      .be       (bank_be),
      .rdata_p0 (bank_rdata_p0[g])
    );
  end

  // stage p0: request accepted, bank captures read word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      bank_sel <= '0;
    end else begin
      vld_p0 <= acc_rd;
      if (acc) begin
        bank_sel <= bank_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_rd) begin
      rd_bank_p0 <= req_bank;
    end
  end

  // stage p1: response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= vld_p0;
      if (vld_p0) begin
        rsp_rdata <= bank_rdata_p0[rd_bank_p0];
      end
    end
  end

endmodule

// File: tb/tb_banked_memory.sv
// tb_banked_memory
//   Directed + randomized bench for banked_memory at default parameters.
//   A flat-array reference model tracks memory contents, sweep progress,
//   the expected read response and the expected chip select.
module tb_banked_memory;

  localparam int DATA_W = 32;
  localparam int WPB    = 64;
  localparam int NB     = 4;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [NB-1:0]     bank_sel;
  logic              init_done;

  banked_memory #(
    .DATA_W         (DATA_W),
    .WORDS_PER_BANK (WPB),
    .NUM_BANKS      (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bank_sel  (bank_sel),
    .init_done (init_done)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] mem_m [256];
  int          edges;      // clock edges since reset release
  bit          pend_v;     // read accepted on the last edge
  logic [31:0] pend_d;
  bit          exp_v;
  logic [31:0] exp_d;
  logic [3:0]  exp_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    check("req_ready", 32'(req_ready), 32'(edges >= WPB));
    check("init_done", 32'(init_done), 32'(edges >= WPB));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    check("rsp_rdata", rsp_rdata, exp_d);
    check("bank_sel", 32'(bank_sel), 32'(exp_sel));
  endtask

  // One clock cycle with the given request; model advanced on the edge.
  task automatic cyc(input bit v, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    bit acc;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    acc = v && (edges >= WPB);
    @(posedge clk);
    #1;
    exp_v = pend_v;
    if (pend_v) exp_d = pend_d;
    pend_v = acc && (w === 1'b0);
    if (acc && (w === 1'b0)) pend_d = mem_m[a];
    if (acc && (w === 1'b1)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (acc) exp_sel = 4'b0001 << a[7:6];
    edges++;
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'bx, 8'hxx, 32'hxxxxxxxx, 4'hx);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b1, 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    edges  = 0;
    pend_v = 1'b0;
    exp_v  = 1'b0;
    exp_d  = '0;
    exp_sel = '0;
    // sweep will have zeroed everything before the first possible access
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    #2;
    do_reset(3);

    // sweep; requests presented during INIT must be ignored
    for (int i = 0; i < WPB; i++) begin
      if (i < 3 || i == WPB - 1) wr(8'h05, 32'hDEADBEEF, 4'hF);
      else idle();
    end

    // fresh memory reads as zero, including the ignored write target
    rd(8'h00); rd(8'h3F); rd(8'h40); rd(8'hFF); rd(8'h05);
    idle();
    check("rd05_zero", rsp_rdata, 32'h0000_0000);

    // write then read the same word back-to-back
    wr(8'h01, 32'd12, 4'hF);
    check("sel_01", 32'(bank_sel), 32'h1);
    rd(8'h01);
    idle();
    check("rd01", rsp_rdata, 32'h0000_000C);

    // partial byte-lane write
    wr(8'h02, 32'd20, 4'hF);
    wr(8'h02, 32'hAABBCCDD, 4'b0010);
    rd(8'h02);
    idle();
    check("rd02_be", rsp_rdata, 32'h0000_CC14);

    // bank boundary
    wr(8'h3F, 32'h11111111, 4'hF);
    check("sel_3f", 32'(bank_sel), 32'h1);
    wr(8'h40, 32'h22222222, 4'hF);
    check("sel_40", 32'(bank_sel), 32'h2);
    rd(8'h3F);
    idle();
    check("rd3f", rsp_rdata, 32'h11111111);
    rd(8'h40);
    idle();
    check("rd40", rsp_rdata, 32'h22222222);
    wr(8'h02, 32'h0, 4'h0);
    rd(8'h02);
    idle();
    check("rd02_be0", rsp_rdata, 32'h0000_CC14);

    // randomized traffic, back-to-back, biased to a small address pool
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) a = 8'($urandom_range(0, 255));
      else a = {2'($urandom_range(0, 3)), 4'b0000, 2'($urandom_range(0, 3))};
      d = $urandom;
      if ($urandom_range(0, 3) == 0) idle();
      else cyc(1'b1, 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
    end
    idle();

    // reset in the middle of the sweep at index 30
    do_reset(2);
    for (int i = 0; i < 30; i++) idle();
    do_reset(2);
    for (int i = 0; i < WPB; i++) idle();
    rd(8'h02); rd(8'h40);
    idle();
    check("rd40_cleared", rsp_rdata, 32'h0);

    // reset the cycle after a read is accepted: no response may appear
    wr(8'h10, 32'hCAFEF00D, 4'hF);
    rd(8'h10);
    do_reset(2);
    for (int i = 0; i < WPB; i++) idle();
    check("rsp_dropped", rsp_rdata, 32'h0);
    rd(8'h10);
    idle();
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 255));
      cyc(1'b1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
